// File: rtl/module_register_file.sv
// Multi-port register file with a hardwired-zero entry and a sequenced clear.
// Reads are registered (one-cycle latency). Optional write-to-read forwarding.
// A clear pass runs after reset and on clr_req, zeroing one entry per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | zeroing entry r_clr_idx each cycle; reads return 0, writes dropped
//   ST_READY | normal operation; clr_req starts a new clear pass
module module_register_file #(
  parameter int REGISTER_COUNT = 32,
  parameter int REGISTER_WIDTH = 32,
  parameter int ADDRESS_BITS   = 5,
  parameter int READ_PORTS     = 2,
  parameter int ZERO_REG       = REGISTER_COUNT - 1,
  parameter int BYPASS         = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [READ_PORTS*ADDRESS_BITS-1:0]   rd_addr,
  output logic [READ_PORTS*REGISTER_WIDTH-1:0] rd_data,
  input  logic                                 wr_en,
  input  logic [ADDRESS_BITS-1:0]              wr_addr,
  input  logic [REGISTER_WIDTH-1:0]            data_in,
  input  logic                                 clr_req,
  output logic                                 busy,
  output logic                                 wr_drop
);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                              r_state;
  logic [ADDRESS_BITS-1:0]             r_clr_idx;
  logic [REGISTER_WIDTH-1:0]           r_mem [REGISTER_COUNT];
  logic [READ_PORTS*REGISTER_WIDTH-1:0] r_rd_data;
  logic                                r_wr_drop;

  logic [READ_PORTS*REGISTER_WIDTH-1:0] w_rd_next;
  logic                                w_addr_ok;
  logic                                w_wr_ok;
  logic                                w_wr_drop;

  // A write lands only in READY, to a real non-zero entry, and not while a
  // clear is being requested (the clear wins that cycle).
  assign w_addr_ok = int'(wr_addr) < REGISTER_COUNT;
  assign w_wr_ok   = (r_state == ST_READY) && wr_en && !clr_req && w_addr_ok &&
                     (int'(wr_addr) != ZERO_REG);
  // Zero-register writes are silently ignored; everything else that fails is dropped.
  assign w_wr_drop = wr_en && ((r_state == ST_CLEAR) || clr_req || !w_addr_ok);

  // Next read data per port: zero during clear, for the zero entry and for
  // out-of-range addresses; otherwise stored data or forwarded write data.
  always_comb begin
    w_rd_next = '0;
    if (r_state == ST_READY) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if ((int'(rd_addr[p*ADDRESS_BITS +: ADDRESS_BITS]) < REGISTER_COUNT) &&
            (int'(rd_addr[p*ADDRESS_BITS +: ADDRESS_BITS]) != ZERO_REG)) begin
          if ((BYPASS != 0) && w_wr_ok &&
              (rd_addr[p*ADDRESS_BITS +: ADDRESS_BITS] == wr_addr)) begin
            w_rd_next[p*REGISTER_WIDTH +: REGISTER_WIDTH] = data_in;
          end else begin
            w_rd_next[p*REGISTER_WIDTH +: REGISTER_WIDTH] =
              r_mem[rd_addr[p*ADDRESS_BITS +: ADDRESS_BITS]];
          end
        end
      end
    end
  end

  // Control FSM plus registered read data and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
      r_rd_data <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_rd_data <= w_rd_next;
      r_wr_drop <= w_wr_drop;
      case (r_state)
        ST_CLEAR: begin
          if (int'(r_clr_idx) == REGISTER_COUNT - 1) begin
            r_state <= ST_READY;
          end else begin
            r_clr_idx <= r_clr_idx + ADDRESS_BITS'(1);
          end
        end
        ST_READY: begin
          if (clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_idx <= '0;
        end
      endcase
    end
  end

  // Storage array; contents survive reset and are zeroed by the clear pass.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= data_in;
    end
  end

  assign rd_data = r_rd_data;
  assign busy    = (r_state == ST_CLEAR);
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_module_register_file.sv
// Directed bench: default file (bypass on), a bypass-off twin sharing its
// inputs, and a 24-entry / 4-read-port variant with its own inputs.
module tb_module_register_file;

  logic        clk;
  logic        rst_n;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [63:0] b_rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] data_in;
  logic        clr_req;
  logic        a_busy, b_busy, a_drop, b_drop;

  logic [19:0]  c_rd_addr;
  logic [127:0] c_rd_data;
  logic         c_wr_en;
  logic [4:0]   c_wr_addr;
  logic [31:0]  c_data_in;
  logic         c_clr;
  logic         c_busy, c_drop;

  int n_tests = 0;
  int n_fail  = 0;

  module_register_file u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .clr_req(clr_req),
    .busy(a_busy), .wr_drop(a_drop)
  );

  module_register_file #(.BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(b_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in), .clr_req(clr_req),
    .busy(b_busy), .wr_drop(b_drop)
  );

  module_register_file #(.REGISTER_COUNT(24), .ADDRESS_BITS(5), .READ_PORTS(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .data_in(c_data_in), .clr_req(c_clr),
    .busy(c_busy), .wr_drop(c_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [4:0] p0, input logic [4:0] p1);
    a_rd_addr = {p1, p0};
  endtask

  int na, nb, nc, guard;

  initial begin
    rst_n = 1'b0; a_rd_addr = '0; wr_en = 1'b0; wr_addr = '0; data_in = '0; clr_req = 1'b0;
    c_rd_addr = '0; c_wr_en = 1'b0; c_wr_addr = '0; c_data_in = '0; c_clr = 1'b0;

    // Asynchronous reset state, before any clock edge
    #3;
    check_val("rst_busy_a", 64'(a_busy), 64'd1);
    check_val("rst_drop_a", 64'(a_drop), 64'd0);
    check_val("rst_rd_a", a_rd_data, 64'd0);
    check_val("rst_busy_c", 64'(c_busy), 64'd1);
    #9 rst_n = 1'b1;

    // Clear pass length after reset release
    na = 0; nb = 0; nc = 0; guard = 0;
    while ((a_busy || b_busy || c_busy) && guard < 100) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      if (c_busy) nc++;
      guard++;
      tick();
    end
    check_val("init_busy_cycles_a", 64'(na), 64'd32);
    check_val("init_busy_cycles_b", 64'(nb), 64'd32);
    check_val("init_busy_cycles_c", 64'(nc), 64'd24);

    // Every address reads zero after the initial clear
    for (int a = 0; a < 32; a++) begin
      rd2(5'(a), 5'(a));
      c_rd_addr = {4{5'(a)}};
      tick();
      check_val("init_zero_p0", a_rd_data[31:0], 64'd0);
      check_val("init_zero_p1", a_rd_data[63:32], 64'd0);
      check_val("init_zero_c", c_rd_data[31:0], 64'd0);
    end

    // Write r5, read on both ports the following cycle
    rd2(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd5; data_in = 32'hDEADBEEF;
    tick();
    check_val("wr5_drop", 64'(a_drop), 64'd0);
    wr_en = 1'b0;
    rd2(5'd5, 5'd5);
    tick();
    check_val("rd5_p0", a_rd_data[31:0], 64'hDEADBEEF);
    check_val("rd5_p1", a_rd_data[63:32], 64'hDEADBEEF);
    check_val("rd5_b_p0", b_rd_data[31:0], 64'hDEADBEEF);

    // Same-cycle write/read of r7: forwarded vs old contents
    wr_en = 1'b1; wr_addr = 5'd7; data_in = 32'h11111111;
    rd2(5'd0, 5'd5);
    tick();
    data_in = 32'h12345678;
    rd2(5'd7, 5'd5);
    tick();
    check_val("byp_on_p0", a_rd_data[31:0], 64'h12345678);
    check_val("byp_off_p0", b_rd_data[31:0], 64'h11111111);
    check_val("byp_other_p1", a_rd_data[63:32], 64'hDEADBEEF);
    wr_en = 1'b0;
    tick();
    check_val("r7_after_a", a_rd_data[31:0], 64'h12345678);
    check_val("r7_after_b", b_rd_data[31:0], 64'h12345678);

    // Zero register write is ignored without a drop pulse
    wr_en = 1'b1; wr_addr = 5'd31; data_in = 32'hFFFFFFFF;
    rd2(5'd31, 5'd31);
    tick();
    check_val("zr_drop", 64'(a_drop), 64'd0);
    check_val("zr_byp_p0", a_rd_data[31:0], 64'd0);
    wr_en = 1'b0;
    tick();
    check_val("zr_rd_p0", a_rd_data[31:0], 64'd0);
    check_val("zr_rd_p1", a_rd_data[63:32], 64'd0);

    // Clear request: concurrent write dropped, write during busy dropped,
    // clr_req during clear ignored, contents zeroed afterwards
    wr_en = 1'b1; wr_addr = 5'd3; data_in = 32'hA5A5A5A5;
    tick();
    wr_en = 1'b0; rd2(5'd3, 5'd3);
    tick();
    check_val("r3_set", a_rd_data[31:0], 64'hA5A5A5A5);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; data_in = 32'h44444444;
    tick();
    check_val("clr_busy", 64'(a_busy), 64'd1);
    check_val("clr_wr_drop", 64'(a_drop), 64'd1);
    na = 1;
    clr_req = 1'b0; wr_en = 1'b1; wr_addr = 5'd6; data_in = 32'h66666666;
    tick();
    check_val("busy_wr_drop", 64'(a_drop), 64'd1);
    check_val("busy_rd_zero", a_rd_data[31:0], 64'd0);
    if (a_busy) na++;
    wr_en = 1'b0;
    guard = 0;
    while (a_busy && guard < 100) begin
      clr_req = (na == 10);
      tick();
      if (a_busy) na++;
      guard++;
    end
    clr_req = 1'b0;
    check_val("clr_busy_cycles", 64'(na), 64'd32);
    check_val("post_clr_drop", 64'(a_drop), 64'd0);
    rd2(5'd3, 5'd4);
    tick();
    check_val("r3_cleared", a_rd_data[31:0], 64'd0);
    check_val("r4_dropped", a_rd_data[63:32], 64'd0);
    rd2(5'd5, 5'd6);
    tick();
    check_val("r5_cleared", a_rd_data[31:0], 64'd0);
    check_val("r6_dropped", a_rd_data[63:32], 64'd0);

    // 24-entry variant: out-of-range write, valid write on all 4 ports, zero reg
    c_wr_en = 1'b1; c_wr_addr = 5'd28; c_data_in = 32'hCAFEF00D;
    tick();
    check_val("c_oor_drop", 64'(c_drop), 64'd1);
    c_wr_en = 1'b0; c_rd_addr = {4{5'd28}};
    tick();
    check_val("c_drop_clears", 64'(c_drop), 64'd0);
    check_val("c_rd28", c_rd_data[63:0], 64'd0);
    c_wr_en = 1'b1; c_wr_addr = 5'd10; c_data_in = 32'h0BADC0DE;
    tick();
    check_val("c_wr10_drop", 64'(c_drop), 64'd0);
    c_wr_en = 1'b1; c_wr_addr = 5'd23; c_data_in = 32'h77777777;
    c_rd_addr = {4{5'd10}};
    tick();
    check_val("c_zr_drop", 64'(c_drop), 64'd0);
    check_val("c_rd10_p0", c_rd_data[31:0], 64'h0BADC0DE);
    check_val("c_rd10_p1", c_rd_data[63:32], 64'h0BADC0DE);
    check_val("c_rd10_p2", c_rd_data[95:64], 64'h0BADC0DE);
    check_val("c_rd10_p3", c_rd_data[127:96], 64'h0BADC0DE);
    c_wr_en = 1'b0; c_rd_addr = {5'd10, 5'd23, 5'd23, 5'd23};
    tick();
    check_val("c_rd23", c_rd_data[95:0], 64'd0);
    check_val("c_rd10_mix", c_rd_data[127:96], 64'h0BADC0DE);

    // Reset asserted mid-clear clears outputs immediately and restarts the pass
    wr_en = 1'b1; wr_addr = 5'd8; data_in = 32'h0F0F0F0F;
    tick();
    wr_en = 1'b0; rd2(5'd8, 5'd8);
    tick();
    check_val("r8_set", a_rd_data[31:0], 64'h0F0F0F0F);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    check_val("midclr_busy", 64'(a_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", 64'(a_busy), 64'd1);
    check_val("arst_rd", a_rd_data, 64'd0);
    rst_n = 1'b1;
    na = 0; guard = 0;
    while (a_busy && guard < 100) begin
      na++;
      guard++;
      tick();
    end
    check_val("restart_busy_cycles", 64'(na), 64'd32);
    tick();
    check_val("r8_cleared", a_rd_data[31:0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
